// File: rtl/psa_search_engine.sv
// Pattern-search engine: caches a pattern from one BRAM and slides a data BRAM block past it.
// Optional macro PSA_WILDCARD_EN adds a WILDCARD pattern word that matches any data word.
module psa_search_engine #(
   parameter int AW     = 8,
   parameter int DW     = 8,
   parameter int MAX_PL = 16,
   parameter int CW     = 8
`ifdef PSA_WILDCARD_EN
   ,
   parameter logic [DW-1:0] WILDCARD = '1
`endif
) (
   input  logic          CLK100MHZ,
   input  logic          reset_n,
   input  logic          start,
   input  logic          mode,
   input  logic          resume,
   input  logic [AW-1:0] p,
   input  logic [AW-1:0] pl,
   input  logic [AW-1:0] b,
   input  logic [AW-1:0] bl,
   output logic [AW-1:0] addr_p,
   input  logic [DW-1:0] dout_p,
   output logic [AW-1:0] addr_d,
   input  logic [DW-1:0] dout_d,
   output logic          busy,
   output logic          match_valid,
   output logic [AW-1:0] found,
   output logic [CW-1:0] match_count,
   output logic          done,
   output logic          err
);
   localparam int FW = $clog2(MAX_PL + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_PAUSE, S_DONE} state_t;

   state_t        state;
   logic          mode_reg;
   logic [AW-1:0] pl_reg;
   logic [AW-1:0] b_reg;
   logic [AW-1:0] bl_reg;
   logic [FW-1:0] ld_cnt;
   logic [FW-1:0] fill;
   logic [AW-1:0] issue_cnt;
   logic [AW-1:0] recv_cnt;
   logic          rd_vld;
   logic          win_vld;

   // Both arrays hold the newest word at index 0, so slot k of the window lines up with slot k of the pattern.
   logic [DW-1:0]     window [MAX_PL];
   logic [DW-1:0]     pat    [MAX_PL];
   logic [MAX_PL-1:0] elem_ok;

   logic req_bad;
   logic pat_shift;
   logic win_shift;
   logic hit;
   logic pause_now;
   logic last_cmp;

   assign req_bad   = (pl == '0) || (32'(pl) > MAX_PL) || (pl > bl);
   assign pat_shift = (state == S_LOAD) && (ld_cnt != '0);
   assign hit       = (state == S_SCAN) && win_vld && (32'(fill) >= 32'(pl_reg)) && (&elem_ok);
   assign pause_now = hit && !mode_reg;
   // A pausing match drops the word arriving this cycle; its address is re-issued on resume.
   assign win_shift = (state == S_SCAN) && rd_vld && !pause_now;
   assign last_cmp  = win_vld && (recv_cnt == bl_reg);

   generate
      for (genvar gi = 0; gi < MAX_PL; gi++) begin : g_cmp
         logic in_pat;
         logic eq;
         assign in_pat = (32'(pl_reg) > gi);
`ifdef PSA_WILDCARD_EN
         assign eq = (window[gi] == pat[gi]) || (pat[gi] == WILDCARD);
`else
         assign eq = (window[gi] == pat[gi]);
`endif
         assign elem_ok[gi] = !in_pat || eq;
      end
   endgenerate

   always_ff @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         mode_reg    <= 1'b0;
         pl_reg      <= '0;
         b_reg       <= '0;
         bl_reg      <= '0;
         ld_cnt      <= '0;
         fill        <= '0;
         issue_cnt   <= '0;
         recv_cnt    <= '0;
         rd_vld      <= 1'b0;
         win_vld     <= 1'b0;
         addr_p      <= '0;
         addr_d      <= '0;
         busy        <= 1'b0;
         match_valid <= 1'b0;
         found       <= '0;
         match_count <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         for (int i = 0; i < MAX_PL; i++) begin
            window[i] <= '0;
            pat[i]    <= '0;
         end
      end else begin
         match_valid <= 1'b0;
         win_vld     <= win_shift;

         if (pat_shift) begin
            pat[0] <= dout_p;
            for (int i = 1; i < MAX_PL; i++) pat[i] <= pat[i-1];
         end

         if (win_shift) begin
            window[0] <= dout_d;
            for (int i = 1; i < MAX_PL; i++) window[i] <= window[i-1];
            fill     <= (32'(fill) >= MAX_PL) ? fill : fill + FW'(1);
            recv_cnt <= recv_cnt + AW'(1);
         end

         if (hit) begin
            match_valid <= 1'b1;
            found       <= b_reg + recv_cnt - pl_reg;
            match_count <= (match_count == '1) ? match_count : match_count + CW'(1);
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  mode_reg    <= mode;
                  pl_reg      <= pl;
                  b_reg       <= b;
                  bl_reg      <= bl;
                  found       <= '0;
                  match_count <= '0;
                  ld_cnt      <= '0;
                  fill        <= '0;
                  issue_cnt   <= '0;
                  recv_cnt    <= '0;
                  rd_vld      <= 1'b0;
                  addr_p      <= p;
                  addr_d      <= b;
                  done        <= req_bad;
                  err         <= req_bad;
                  if (req_bad) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_LOAD;
                     busy  <= 1'b1;
                  end
               end
            end

            S_LOAD: begin
               ld_cnt <= ld_cnt + FW'(1);
               if (32'(ld_cnt) + 1 < 32'(pl_reg)) addr_p <= addr_p + AW'(1);
               if (32'(ld_cnt) == 32'(pl_reg)) state <= S_SCAN;
            end

            S_SCAN: begin
               if (issue_cnt < bl_reg) begin
                  rd_vld    <= 1'b1;
                  issue_cnt <= issue_cnt + AW'(1);
                  addr_d    <= addr_d + AW'(1);
               end else begin
                  rd_vld <= 1'b0;
               end
               if (pause_now) begin
                  state     <= S_PAUSE;
                  rd_vld    <= 1'b0;
                  issue_cnt <= recv_cnt;
                  addr_d    <= b_reg + recv_cnt;
               end else if (last_cmp) begin
                  state  <= S_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  rd_vld <= 1'b0;
               end
            end

            S_PAUSE: begin
               if (resume) begin
                  if (recv_cnt == bl_reg) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= S_SCAN;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/psa_search_engine.md
Name: psa_search_engine

Overview:
- Parametrised pattern-search accelerator for the PSA datapath.
- Caches a pattern of up to MAX_PL words from the pattern BRAM, then streams a block of the data BRAM through a sliding window, comparing every alignment in one cycle.
- Two modes: FIRST pauses at each match until `resume`; ALL reports every match without stalling and counts them.
- Connects to two 1-cycle-latency BRAM read ports.

Parameters:
- AW, 8, address width of both BRAMs; also the width of the lengths.
- DW, 8, data word width.
- MAX_PL, 16, maximum pattern length; sets the window and pattern register depth.
- CW, 8, width of the match counter.

Ports:
- CLK100MHZ  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches p, pl, b, bl, mode; accepted only in IDLE or DONE.
- mode  in  1  0 = FIRST (pause on match), 1 = ALL (free-running).
- resume  in  1  continue after a paused match; ignored in other states.
- p  in  AW  pattern base address.
- pl  in  AW  pattern length.
- b  in  AW  block base address.
- bl  in  AW  block length.
- addr_p  out  AW  pattern BRAM address.
- dout_p  in  DW  pattern BRAM data, valid 1 cycle after addr_p.
- addr_d  out  AW  data BRAM address.
- dout_d  in  DW  data BRAM data, valid 1 cycle after addr_d.
- busy  out  1  high in LOAD, SCAN, PAUSE.
- match_valid  out  1  one-cycle pulse per match.
- found  out  AW  start address of the latest match; holds until the next match or start.
- match_count  out  CW  number of matches since start; saturates at all-ones.
- done  out  1  high in DONE until the next start.
- err  out  1  high with done when parameters were invalid.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; addr_p, addr_d, found, match_count = 0; busy, match_valid, done, err = 0; window and pattern registers cleared.
- All address arithmetic is modulo 2^AW, so a block or pattern crossing the top address wraps to 0.
- IDLE/DONE + start:
  - Invalid request (pl==0, pl>MAX_PL, or pl>bl) -> DONE next cycle with err=1 and match_count=0.
  - Otherwise -> LOAD; done, err, found and match_count are cleared.
- LOAD:
  - Issue addr_p = p+i for i = 0..pl-1, one per cycle.
  - Capture dout_p into pat[i] one cycle later.
  - Lasts pl+1 cycles, then -> SCAN.
- SCAN:
  - Issue addr_d = b+j for j = 0..bl-1, one per cycle.
  - Each returned word shifts into the window (newest at index 0); a fill counter tracks valid entries.
  - When fill >= pl and window[pl-1..0] equals pat[0..pl-1] for the word from address A:
    - match_valid pulses on the following cycle;
    - found = A-pl+1 (mod 2^AW);
    - match_count increments (saturating).
  - Overlapping matches all count (pattern AA in AAA gives 2 matches).
- FIRST mode on a match -> PAUSE:
  - Address issue stops; the in-flight word is discarded.
  - On resume, the discarded address is re-issued and the window is preserved, so no alignment is skipped or repeated.
- ALL mode: never pauses; one word per cycle.
- Completion: SCAN -> DONE once the last word is compared. With no pause, done rises bl+2 cycles after entering SCAN.
  - A match on the final word still pulses match_valid, with done rising in the same cycle.
  - In FIRST mode, a match on the final word goes to PAUSE first; resume then -> DONE.
- start while busy is ignored.
- resume and start in the same PAUSE cycle: resume wins.
- Asserting reset_n low mid-operation aborts immediately to reset values; BRAM contents are untouched.

Optional Feature:
- Macro: PSA_WILDCARD_EN.
- When defined: adds parameter WILDCARD (default all-ones). A pattern word equal to WILDCARD matches any data word at that position. If every pattern word is WILDCARD, every alignment matches.
- When not defined: no WILDCARD parameter exists, and comparison is strict equality on all DW bits.

Test Plan:
- Pattern mem[10..11] = 0x41,0x42; data mem[145..174] holds 0x41,0x42 at 150 and 160; start with p=10, pl=2, b=145, bl=30, mode=0 -> match_valid with found=150, busy stays high (paused); resume -> found=160; resume -> done=1, match_count=2, err=0.
- Same memories, mode=1 -> two match_valid pulses (found=150 then 160) with no stall; done exactly 32 cycles after SCAN entry; match_count=2.
- Data 0xAA at 200..202, pattern 0xAA,0xAA, b=200, bl=3, mode=1 -> matches at found=200 and 201; match_count=2.
- Wrap-around: pattern 0x12,0x34 with data mem[255]=0x12, mem[0]=0x34; b=250, bl=10 -> found=255, done, err=0.
- Invalid requests: pl=0 -> done=1, err=1 one cycle after start; pl=17 with MAX_PL=16 -> same. Pulling reset_n low during SCAN -> all outputs return to reset values asynchronously.
- With PSA_WILDCARD_EN defined: pattern 0x41,0xFF,0x43 against data 0x41,0x7E,0x43 -> match found; with the macro undefined, the same stimulus gives no match and match_count=0.
